sd_rx_word_packer: RTL
======================

Name: sd_rx_word_packer

Overview:
- Sits directly downstream of the SD data serial host on the read path.
- Consumes the 4-bit nibble stream (data nibble plus write strobe) that the host produces during block reads.
- Packs eight nibbles into one 32-bit word and writes the words into the RX FIFO through a 2-entry skid buffer, because the serial host cannot be stalled.
- Tracks block completion and reports overflow.

Parameters:
- BLOCK_NIBBLES, 1024: nibbles per data block (512 bytes x 2); must be a multiple of 8.
- BIG_ENDIAN, 1: 1 = first nibble received lands in [31:28]; 0 = first nibble lands in [3:0].
- CNT_W, 11: width of the nibble counter; must hold BLOCK_NIBBLES.

Ports:
- sd_clk, input, 1: SD card clock; all state changes on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- nib_in, input, 4: data nibble from the serial host; stable at the sd_clk rising edge (the host drives it on the falling edge).
- nib_we, input, 1: nib_in is valid this cycle.
- flush, input, 1: pad and push any partial word, then finish the block.
- clr, input, 1: synchronous abort/restart of the block; highest priority.
- fifo_full, input, 1: RX FIFO cannot accept a write this cycle.
- fifo_data, output, 32: word presented to the FIFO (head of the skid buffer).
- fifo_wr, output, 1: write strobe; a write occurs at an edge where fifo_wr=1.
- word_cnt, output, CNT_W-3: words written to the FIFO this block.
- block_done, output, 1: one-cycle pulse when the block has fully drained.
- overflow, output, 1: sticky flag; a word or nibble was dropped.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Outputs: fifo_data=0, fifo_wr=0, word_cnt=0, block_done=0, overflow=0.
  - Internal: state=IDLE, nibble counter=0, shift register=0, skid count=0, read/write pointers=0.
- Packing:
  - Each accepted nibble is inserted into the shift register at the position given by BIG_ENDIAN and the lane index (nibble count mod 8).
  - On the 8th nibble, the completed word, including that nibble, is pushed into the skid buffer in the same edge.
  - Latency: last nibble sampled at edge N; word becomes visible on fifo_data after edge N; earliest FIFO write is at edge N+1.
- FIFO handshake:
  - fifo_wr = (skid count != 0) & !fifo_full. This is combinational from registered state and fifo_full.
  - fifo_data is always the head entry.
  - Pop occurs on an edge where fifo_wr=1; word_cnt increments on that same edge.
- Skid buffer (2 entries, pointers wrap mod 2):
  - Simultaneous push and pop at count 2 is legal; count stays 2.
  - Push at count 2 with no pop drops the new word and sets overflow; contents are unchanged.
- State machine:
  - IDLE:
    - nib_we=1: accept the nibble and go to RECV.
    - flush=1: go to DONE (empty block).
  - RECV:
    - Accept every nib_we.
    - When the nibble counter reaches BLOCK_NIBBLES (the final nibble is accepted on that edge), go to DRAIN.
    - flush=1 with lane index !=0: zero-fill the remaining lanes, push the word in the same edge, go to DRAIN.
    - flush=1 with lane index =0: go to DRAIN.
  - DRAIN:
    - nib_we=1 is not accepted and sets overflow.
    - When skid count=0 with no push pending, go to DONE.
  - DONE: block_done=1 for exactly this cycle, then go to IDLE. word_cnt holds its value until the next clr or the first nib_we in IDLE, which resets it to 0.
- Priority and simultaneous events:
  - clr=1 in any state:
    - Go to IDLE; clear nibble counter, shift register, skid buffer, pointers, word_cnt and overflow.
    - A same-cycle nib_we or flush is ignored.
    - A write to the FIFO that same cycle is suppressed: fifo_wr is forced to 0 while clr=1.
  - flush and nib_we together in RECV: the nibble is accepted first, then the flush rules apply to the resulting lane index.
  - Reset mid-block: all state is lost, no partial word is emitted, and fifo_wr drops immediately.

Test Plan:
- Nominal: 16 nibbles 0x1..0x8, 0x9..0xF, 0x0 with BIG_ENDIAN=1, BLOCK_NIBBLES=16, fifo_full=0.
  - FIFO writes 0x12345678 then 0x9ABCDEF0, word_cnt=2, block_done pulses once, overflow=0.
  - Repeat with BIG_ENDIAN=0: writes 0x87654321 and 0x0FEDCBA9.
- Backpressure: hold fifo_full=1 during a 24-nibble stream (BLOCK_NIBBLES=24).
  - Two words buffered, the third word dropped, overflow=1.
  - Release fifo_full: exactly 2 writes, then block_done.
- Simultaneous push/pop: skid count=2, release fifo_full on the same edge that the 8th nibble of the next word arrives.
  - Count stays 2, no overflow, word order preserved.
- Flush partial: 3 nibbles 0xA,0xB,0xC, then flush (BIG_ENDIAN=1).
  - One write 0xABC00000, word_cnt=1, block_done pulses.
- Abort: clr asserted mid-word after 5 nibbles, with fifo_full=1 and one word buffered.
  - No write occurs, word_cnt=0, overflow cleared, state IDLE.
  - A following full 16-nibble block packs correctly from lane 0.
- Async reset: assert rst_n=0 between edges while fifo_wr=1.
  - fifo_wr and all other outputs go to 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/sd_rx_word_packer_if.sv
// Read-path bundle between the SD data serial host, the word packer and the RX FIFO.
// slave is the packer's view; master is the view of whatever drives the nibble
// stream and sinks the FIFO writes.
interface sd_rx_word_packer_if #(
  parameter int unsigned CNT_W = 11
);
  logic [3:0]       nib_in;
  logic             nib_we;
  logic             flush;
  logic             clr;
  logic             fifo_full;
  logic [31:0]      fifo_data;
  logic             fifo_wr;
  logic [CNT_W-4:0] word_cnt;
  logic             block_done;
  logic             overflow;

  modport master (
    output nib_in, nib_we, flush, clr, fifo_full,
    input  fifo_data, fifo_wr, word_cnt, block_done, overflow
  );

  modport slave (
    input  nib_in, nib_we, flush, clr, fifo_full,
    output fifo_data, fifo_wr, word_cnt, block_done, overflow
  );
endinterface

// File: rtl/sd_rx_word_packer.sv
// Packs the SD serial host's 4-bit read nibble stream into 32-bit words and
// feeds them to the RX FIFO through a 2-entry skid buffer. The host cannot be
// stalled, so words that do not fit are dropped and flagged as overflow.
module sd_rx_word_packer #(
  parameter int unsigned BLOCK_NIBBLES = 1024,
  parameter bit          BIG_ENDIAN    = 1'b1,
  parameter int unsigned CNT_W         = 11
) (
  input  logic                 sd_clk,
  input  logic                 rst_n,
  sd_rx_word_packer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RECV, DRAIN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] nib_cnt;
  logic [31:0]      shreg;
  logic [31:0]      skid [2];
  logic             wp;
  logic             rp;
  logic [1:0]       skid_cnt;
  logic [CNT_W-4:0] word_cnt_q;
  logic             block_done_q;
  logic             overflow_q;

  logic             accept;
  logic [2:0]       lane;
  logic [4:0]       off;
  logic [31:0]      shreg_ins;
  logic [CNT_W-1:0] cnt_next;
  logic             word_push;
  logic             flush_push;
  logic             push;
  logic             pop;
  logic             push_ok;
  logic             drop;
  logic             fifo_wr_c;

  assign fifo_wr_c      = (skid_cnt != 2'd0) && !bus.fifo_full && !bus.clr;
  assign bus.fifo_wr    = fifo_wr_c;
  assign bus.fifo_data  = skid[rp];
  assign bus.word_cnt   = word_cnt_q;
  assign bus.block_done = block_done_q;
  assign bus.overflow   = overflow_q;

  // Nibble insertion, word completion and skid push/pop decisions for this edge.
  always_comb begin
    accept = !bus.clr && bus.nib_we && (state == IDLE || state == RECV);
    lane   = nib_cnt[2:0];
    off    = {lane, 2'b00};
    if (BIG_ENDIAN) off = 5'd28 - off;
    shreg_ins = shreg;
    if (accept) shreg_ins[off +: 4] = bus.nib_in;
    cnt_next   = nib_cnt + CNT_W'(accept);
    word_push  = accept && (lane == 3'd7);
    // Flush sees the lane index after any same-cycle nibble has been taken;
    // unfilled lanes are already zero because shreg is cleared per word.
    flush_push = !bus.clr && (state == RECV) && bus.flush && (cnt_next[2:0] != 3'd0);
    push       = word_push || flush_push;
    pop        = fifo_wr_c;
    push_ok    = push && ((skid_cnt != 2'd2) || pop);
    drop       = push && (skid_cnt == 2'd2) && !pop;
  end

  // Block state machine, packer, skid buffer and registered status outputs.
  always_ff @(posedge sd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      nib_cnt      <= '0;
      shreg        <= '0;
      for (int unsigned i = 0; i < 2; i++) skid[i] <= '0;
      wp           <= 1'b0;
      rp           <= 1'b0;
      skid_cnt     <= '0;
      word_cnt_q   <= '0;
      block_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else if (bus.clr) begin
      state        <= IDLE;
      nib_cnt      <= '0;
      shreg        <= '0;
      for (int unsigned i = 0; i < 2; i++) skid[i] <= '0;
      wp           <= 1'b0;
      rp           <= 1'b0;
      skid_cnt     <= '0;
      word_cnt_q   <= '0;
      block_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      block_done_q <= 1'b0;

      if (pop) begin
        rp         <= ~rp;
        word_cnt_q <= word_cnt_q + 1'b1;
      end
      if (push_ok) begin
        skid[wp] <= shreg_ins;
        wp       <= ~wp;
      end
      skid_cnt <= skid_cnt + 2'(push_ok) - 2'(pop);

      if (drop || (state == DRAIN && bus.nib_we)) overflow_q <= 1'b1;

      if (accept) begin
        nib_cnt <= cnt_next;
        shreg   <= word_push ? '0 : shreg_ins;
      end

      case (state)
        IDLE: begin
          if (bus.nib_we) begin
            state      <= RECV;
            word_cnt_q <= '0;
          end else if (bus.flush) begin
            state        <= DONE;
            block_done_q <= 1'b1;
          end
        end
        RECV: begin
          if (cnt_next == CNT_W'(BLOCK_NIBBLES)) begin
            state <= DRAIN;
          end else if (bus.flush) begin
            state <= DRAIN;
            shreg <= '0;
          end
        end
        DRAIN: begin
          if (skid_cnt == 2'd0) begin
            state        <= DONE;
            block_done_q <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          nib_cnt <= '0;
          shreg   <= '0;
        end
      endcase
    end
  end

endmodule
